resp_capture_checker: RTL and testbench
=======================================

// Module: resp_capture_checker
// PURPOSE
//  Downstream capture stage for the optimized 14-in/8-out combinational netlist.
//  - Accepts one response vector per handshake (the netlist outputs n6..n77 packed as resp[7:0]).
//  - Compares each response against the golden-model vector exp[7:0].
//  - Counts mismatches and records the first failing vector; optionally compacts responses into a MISR signature.
//  - Reports pass/fail after a programmed number of vectors.
// PARAMETERS
//  OUT_W      8       response/expected vector width
//  CNT_W      16      width of vector count, index and mismatch counter
//  MISR_POLY  8'hB8   MISR feedback polynomial mask (OUT_W bits)
//  MISR_SEED  8'hFF   MISR reset/start value (OUT_W bits)
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      synchronous reset, active-low
//  start       in   1      one-cycle pulse; begins a run
//  num_vec     in   CNT_W  vectors in this run, sampled on accepted start
//  in_valid    in   1      resp/exp valid
//  in_ready    out  1      stage can accept a vector
//  resp        in   OUT_W  netlist response {n77,n68,n65,n56,n48,n42,n9,n6}
//  exp         in   OUT_W  golden expected response
//  busy        out  1      run in progress
//  done        out  1      run complete; held until next start
//  pass        out  1      done && mism_cnt==0
//  mism_cnt    out  CNT_W  mismatching vectors in this run, saturating
//  first_idx   out  CNT_W  index (0-based) of first mismatching vector
//  first_diff  out  OUT_W  resp^exp of first mismatching vector
//  signature   out  OUT_W  MISR value (see CONFIGURATION)
// BEHAVIOUR
//  Reset (clk edge with rst_n=0):
//  - state=IDLE; in_ready, busy, done, pass, mism_cnt, first_idx, first_diff all 0.
//  - signature=MISR_SEED; internal idx=0.
//  FSM:
//  - IDLE: start & num_vec!=0 -> RUN. start & num_vec==0 -> DONE with pass=1.
//  - RUN: in_ready=1 (combinational from state); accept on in_valid&&in_ready.
//    Last accept (idx==num_vec-1) -> DONE.
//  - DONE: done=1. start -> RUN, or DONE if num_vec==0. start is ignored while in RUN.
//  On start accepted (IDLE or DONE):
//  - clear mism_cnt, first_idx, first_diff, done, pass and idx.
//  - load signature=MISR_SEED and latch num_vec.
//  Per accepted vector:
//  - d=resp^exp. If d!=0:
//    - mism_cnt <= mism_cnt+1, saturating at all-ones.
//    - If first mismatch of the run: first_idx<=idx and first_diff<=d.
//  - idx <= idx+1.
//  Latency:
//  - mism_cnt and first_* update on the accepting edge.
//  - done/pass rise one cycle after the last accepting edge and are registered.
//  - busy=1 exactly in RUN.
//  Boundaries:
//  - in_valid is not sampled outside RUN. resp/exp may change freely when in_valid=0.
//  - A vector accepted on the last beat still counts even if start is asserted on the same edge.
//  - rst_n low mid-run aborts and returns to the reset values on that edge; nothing partial survives.
//  - num_vec=all-ones runs the full count; idx never wraps within a run.
// CONFIGURATION
//  RESP_MISR_EN defined:
//  - On each accept, signature <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : 0) ^ resp.
//  - The value is held in DONE.
//  RESP_MISR_EN undefined:
//  - No MISR register; signature is tied to 0.
//  - Port list unchanged; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> all outputs 0, signature=8'hFF (MISR) or 0, in_ready=0.
//  2 num_vec=4, 4 vectors resp==exp, in_valid held 1:
//    -> 4 accepts, done=1 and pass=1 one cycle after the 4th, mism_cnt=0.
//  3 num_vec=5, vectors 2 and 4 differ (resp=8'h3C, exp=8'h34 at idx2):
//    -> mism_cnt=2, first_idx=2, first_diff=8'h08, pass=0.
//  4 in_valid toggled 1,0,0,1,... and start pulsed mid-RUN:
//    -> accepts only on valid cycles, start ignored, count exact.
//  5 start with num_vec=0 -> DONE next cycle, pass=1, no vector accepted.
//    rst_n=0 after 2 of 6 vectors -> reset values, no done.
//  6 RESP_MISR_EN, seed 8'hFF, POLY 8'hB8, resp=8'h01 then 8'h80:
//    -> signature 8'h47 then 8'h0E, matches bench reference model.

Source files
------------

// File: rtl/resp_capture_checker.sv
// -----------------------------------------------------------------------------
// resp_capture_checker
//  Capture stage behind the 14-in/8-out combinational netlist. It takes one
//  response vector per valid/ready handshake and compares it with the golden
//  vector. It counts mismatches (saturating) and records the index and
//  difference pattern of the first mismatch. After a programmed number of
//  vectors it reports done/pass.
//
//  Optional feature: define RESP_MISR_EN to compact every accepted response
//  into a MISR signature. When the macro is undefined, signature is tied to 0.
//
// Ports
//  clk        rising-edge clock for all state
//  rst_n      synchronous active-low reset
//  start      one-cycle run start pulse (ignored while busy)
//  num_vec    vectors in the run, latched when start is accepted
//  in_valid   resp/exp valid
//  in_ready   stage accepts a vector (high exactly in RUN)
//  resp       netlist response {n77,n68,n65,n56,n48,n42,n9,n6}
//  exp        golden expected response
//  busy       run in progress
//  done       run complete, held until the next accepted start
//  pass       done with zero mismatches
//  mism_cnt   mismatching vectors in this run, saturating
//  first_idx  0-based index of the first mismatching vector
//  first_diff resp^exp of the first mismatching vector
//  signature  MISR value, or 0 without RESP_MISR_EN
// -----------------------------------------------------------------------------
module resp_capture_checker #(
   parameter int               OUT_W     = 8,
   parameter int               CNT_W     = 16,
   parameter logic [OUT_W-1:0] MISR_POLY = 8'hB8,
   parameter logic [OUT_W-1:0] MISR_SEED = 8'hFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OUT_W-1:0] resp,
   input  logic [OUT_W-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mism_cnt,
   output logic [CNT_W-1:0] first_idx,
   output logic [OUT_W-1:0] first_diff,
   output logic [OUT_W-1:0] signature
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] num_lat;
   logic             accept;
   logic             last_beat;
   logic [OUT_W-1:0] diff;

   // One MISR step: shift left, fold the feedback mask on MSB, then mix in data.
   function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] sig,
                                                  input logic [OUT_W-1:0] data);
      logic [OUT_W-1:0] fb;
      fb = sig[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}};
      return {sig[OUT_W-2:0], 1'b0} ^ fb ^ data;
   endfunction

   assign in_ready  = (state == RUN);
   assign busy      = (state == RUN);
   assign accept    = in_valid && (state == RUN);
   assign diff      = resp ^ exp;
   // idx never exceeds num_lat-1 inside a run, so an all-ones count cannot wrap.
   assign last_beat = (idx == (num_lat - {{(CNT_W-1){1'b0}}, 1'b1}));

`ifdef RESP_MISR_EN
   logic [OUT_W-1:0] sig;
   assign signature = sig;
`else
   assign signature = {OUT_W{1'b0}};
`endif

   // Run-control FSM plus the result registers it owns.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         done       <= 1'b0;
         pass       <= 1'b0;
         mism_cnt   <= {CNT_W{1'b0}};
         first_idx  <= {CNT_W{1'b0}};
         first_diff <= {OUT_W{1'b0}};
         idx        <= {CNT_W{1'b0}};
         num_lat    <= {CNT_W{1'b0}};
`ifdef RESP_MISR_EN
         sig        <= MISR_SEED;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  mism_cnt   <= {CNT_W{1'b0}};
                  first_idx  <= {CNT_W{1'b0}};
                  first_diff <= {OUT_W{1'b0}};
                  idx        <= {CNT_W{1'b0}};
                  num_lat    <= num_vec;
`ifdef RESP_MISR_EN
                  sig        <= MISR_SEED;
`endif
                  state      <= (num_vec == {CNT_W{1'b0}}) ? DONE : RUN;
               end else if ((state == DONE) && !done) begin
                  // done/pass are raised on the edge after DONE is entered.
                  done <= 1'b1;
                  pass <= (mism_cnt == {CNT_W{1'b0}});
               end
            end
            RUN: begin
               if (accept) begin
                  if (diff != {OUT_W{1'b0}}) begin
                     if (mism_cnt != {CNT_W{1'b1}}) begin
                        mism_cnt <= mism_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                     end
                     // A saturated counter is never zero, so this flags only the first miss.
                     if (mism_cnt == {CNT_W{1'b0}}) begin
                        first_idx  <= idx;
                        first_diff <= diff;
                     end
                  end
                  idx <= idx + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef RESP_MISR_EN
                  sig <= misr_next(sig, resp);
`endif
                  if (last_beat) begin
                     state <= DONE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_resp_capture_checker.sv
// -----------------------------------------------------------------------------
// tb_resp_capture_checker
//  Directed bench for resp_capture_checker. It drives a linear sequence of
//  runs: reset, clean run, mismatching run, gapped valid with an ignored
//  start, a zero-length run and a mid-run reset, and a MISR run. Expected
//  values are hand-computed constants plus a small MISR reference model.
//  Signature expectations follow RESP_MISR_EN.
// -----------------------------------------------------------------------------
module tb_resp_capture_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num_vec;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  resp;
   logic [7:0]  exp;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] mism_cnt;
   logic [15:0] first_idx;
   logic [7:0]  first_diff;
   logic [7:0]  signature;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  msig;

   always #5 clk = ~clk;

   resp_capture_checker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_vec    (num_vec),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .resp       (resp),
      .exp        (exp),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .mism_cnt   (mism_cnt),
      .first_idx  (first_idx),
      .first_diff (first_diff),
      .signature  (signature)
   );

   // Reference MISR step.
   function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] d);
      logic [7:0] t;
      t = {s[6:0], 1'b0};
      if (s[7]) t = t ^ 8'hB8;
      return t ^ d;
   endfunction

   // Expected signature port value for a given model state.
   function automatic logic [7:0] sig_exp(input logic [7:0] s);
`ifdef RESP_MISR_EN
      return s;
`else
      return 8'h00;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic vec(input logic [7:0] r, input logic [7:0] e);
      in_valid = 1'b1; resp = r; exp = e;
      tick();
      msig = misr_ref(msig, r);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_vec = 16'd0; in_valid = 1'b0;
      resp = 8'h00; exp = 8'h00; msig = 8'hFF;

      // 1 reset
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_mism", mism_cnt, 0);
      chk("rst_fidx", first_idx, 0);
      chk("rst_fdiff", first_diff, 0);
      chk("rst_sig", signature, sig_exp(8'hFF));
      rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // 2 four clean vectors with in_valid held high
      start = 1'b1; num_vec = 16'd4; tick(); start = 1'b0;
      chk("t2_busy", busy, 1);
      chk("t2_ready", in_ready, 1);
      msig = 8'hFF;
      vec(8'h11, 8'h11); vec(8'h22, 8'h22); vec(8'h33, 8'h33); vec(8'h44, 8'h44);
      in_valid = 1'b0;
      chk("t2_busy_end", busy, 0);
      chk("t2_mism", mism_cnt, 0);
      tick();
      chk("t2_done", done, 1);
      chk("t2_pass", pass, 1);
      chk("t2_sig", signature, sig_exp(msig));

      // 3 five vectors, idx2 and idx4 mismatch
      start = 1'b1; num_vec = 16'd5; tick(); start = 1'b0;
      chk("t3_done_clr", done, 0);
      chk("t3_pass_clr", pass, 0);
      chk("t3_busy", busy, 1);
      chk("t3_sig_seed", signature, sig_exp(8'hFF));
      msig = 8'hFF;
      vec(8'hA5, 8'hA5); vec(8'h5A, 8'h5A); vec(8'h3C, 8'h34);
      chk("t3_mism1", mism_cnt, 1);
      chk("t3_fidx1", first_idx, 2);
      chk("t3_fdiff1", first_diff, 8'h08);
      vec(8'h77, 8'h77); vec(8'h0F, 8'hF0);
      in_valid = 1'b0;
      chk("t3_mism2", mism_cnt, 2);
      chk("t3_fidx2", first_idx, 2);
      chk("t3_fdiff2", first_diff, 8'h08);
      tick();
      chk("t3_done", done, 1);
      chk("t3_pass", pass, 0);

      // 4 gapped valid, start mid-run and on the last beat
      start = 1'b1; num_vec = 16'd3; tick(); start = 1'b0;
      msig = 8'hFF;
      vec(8'h01, 8'h01);
      in_valid = 1'b0; resp = 8'hFF; exp = 8'h00; tick();
      start = 1'b1; num_vec = 16'd7; tick(); start = 1'b0;
      chk("t4_gap_mism", mism_cnt, 0);
      chk("t4_start_ign", busy, 1);
      vec(8'h02, 8'h03);
      in_valid = 1'b0; resp = 8'hAA; exp = 8'h55; tick();
      chk("t4_mism_mid", mism_cnt, 1);
      chk("t4_fidx", first_idx, 1);
      chk("t4_fdiff", first_diff, 8'h01);
      start = 1'b1;
      vec(8'h0C, 8'h0C);
      start = 1'b0; in_valid = 1'b0;
      chk("t4_busy_end", busy, 0);
      chk("t4_mism_end", mism_cnt, 1);
      tick();
      chk("t4_done", done, 1);
      chk("t4_pass", pass, 0);
      chk("t4_sig", signature, sig_exp(msig));

      // 5a zero-length run; stray valid data must not be taken
      start = 1'b1; num_vec = 16'd0; in_valid = 1'b1; resp = 8'hF0; exp = 8'h0F;
      tick(); start = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;
      chk("t5_done", done, 1);
      chk("t5_pass", pass, 1);
      chk("t5_mism", mism_cnt, 0);
      chk("t5_sig", signature, sig_exp(8'hFF));

      // 5b reset after 2 of 6 vectors
      start = 1'b1; num_vec = 16'd6; tick(); start = 1'b0;
      vec(8'h10, 8'h11); vec(8'h20, 8'h20);
      in_valid = 1'b0;
      chk("t5_mid_mism", mism_cnt, 1);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_mism", mism_cnt, 0);
      chk("t5_rst_fdiff", first_diff, 0);
      chk("t5_rst_sig", signature, sig_exp(8'hFF));
      tick(); tick();
      chk("t5_no_done", done, 0);
      chk("t5_no_busy", busy, 0);

      // 6 MISR reference run
      start = 1'b1; num_vec = 16'd2; tick(); start = 1'b0;
      vec(8'h01, 8'h01);
`ifdef RESP_MISR_EN
      chk("t6_sig1", signature, 8'h47);
`else
      chk("t6_sig1", signature, 8'h00);
`endif
      vec(8'h80, 8'h80);
      in_valid = 1'b0;
`ifdef RESP_MISR_EN
      chk("t6_sig2", signature, 8'h0E);
`else
      chk("t6_sig2", signature, 8'h00);
`endif
      tick();
      chk("t6_sig_hold", signature, sig_exp(8'h0E));
      chk("t6_done", done, 1);
      chk("t6_pass", pass, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
